// File: rtl/ppu_mem_pkg.sv
// Shared types and constants for the PPU-side memory controller.
package ppu_mem_pkg;

    typedef enum logic [2:0] {
        MIR_HORZ  = 3'd0,
        MIR_VERT  = 3'd1,
        MIR_ONE_A = 3'd2,
        MIR_ONE_B = 3'd3,
        MIR_FOUR  = 3'd4
    } mirror_e;

    typedef enum logic [1:0] {
        TGT_CHR = 2'd0,
        TGT_NT  = 2'd1,
        TGT_PAL = 2'd2
    } target_e;

    localparam logic [13:0] CHR_BASE = 14'h0000;
    localparam logic [13:0] NT_BASE  = 14'h2000;
    localparam logic [13:0] PAL_BASE = 14'h3F00;

    // Palette entries 0x10/0x14/0x18/0x1C are the backdrop mirrors of 0x00/0x04/0x08/0x0C.
    function automatic logic [4:0] pal_index(input logic [4:0] a);
        return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
    endfunction

endpackage

// File: rtl/ppu_addr_map.sv
// Combinational PPU address decode: region select, CHR banking,
// nametable mirroring and palette aliasing.
module ppu_addr_map
    import ppu_mem_pkg::*;
#(
    parameter int VRAM_KB    = 2,
    parameter int CHR_BANK_W = 1,
    localparam int VRAM_AW   = (VRAM_KB == 4) ? 12 : 11
) (
    input  logic [13:0]             addr,
    input  logic [2:0]              mirror_mode,
    input  logic [CHR_BANK_W-1:0]   chr_bank0,
    input  logic [CHR_BANK_W-1:0]   chr_bank1,
    output target_e                 tgt,
    output logic [CHR_BANK_W+11:0]  chr_addr,
    output logic [VRAM_AW-1:0]      vram_addr,
    output logic [4:0]              pal_idx
);

    logic [1:0] nt;

    assign nt = addr[11:10];

    // Region select; 0x3000-0x3EFF falls through to the nametable region.
    always_comb begin
        tgt = TGT_NT;
        if (addr[13] == CHR_BASE[13]) begin
            tgt = TGT_CHR;
        end else if (addr[13:8] == PAL_BASE[13:8]) begin
            tgt = TGT_PAL;
        end else if (addr[13] == NT_BASE[13]) begin
            tgt = TGT_NT;
        end
    end

    assign chr_addr = {(addr[12] ? chr_bank1 : chr_bank0), addr[11:0]};
    assign pal_idx  = pal_index(addr[4:0]);

    generate
        if (VRAM_AW == 12) begin : g_four_kb
            logic [1:0] page;

            // Four-screen capable page select.
            always_comb begin
                case (mirror_e'(mirror_mode))
                    MIR_VERT:  page = {1'b0, nt[0]};
                    MIR_ONE_A: page = 2'b00;
                    MIR_ONE_B: page = 2'b01;
                    MIR_FOUR:  page = nt;
                    default:   page = {1'b0, nt[1]};
                endcase
            end

            assign vram_addr = {page, addr[9:0]};
        end else begin : g_two_kb
            logic page;

            // With only two pages, four-screen degrades to vertical mirroring.
            always_comb begin
                case (mirror_e'(mirror_mode))
                    MIR_VERT:  page = nt[0];
                    MIR_ONE_A: page = 1'b0;
                    MIR_ONE_B: page = 1'b1;
                    MIR_FOUR:  page = nt[0];
                    default:   page = nt[1];
                endcase
            end

            assign vram_addr = {page, addr[9:0]};
        end
    endgenerate

endmodule

// File: rtl/ppu_mem_ctrl.sv
// PPU memory controller: three-stage pipeline (translate, access, return)
// over internal nametable VRAM, palette flops and external CHR storage.
module ppu_mem_ctrl
    import ppu_mem_pkg::*;
#(
    parameter int VRAM_KB    = 2,
    parameter int CHR_BANK_W = 1,
    parameter int CHR_RAM    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    we,
    input  logic [13:0]             addr,
    input  logic [7:0]              wdata,
    input  logic [2:0]              mirror_mode,
    input  logic [CHR_BANK_W-1:0]   chr_bank0,
    input  logic [CHR_BANK_W-1:0]   chr_bank1,
    output logic [CHR_BANK_W+11:0]  chr_addr,
    output logic                    chr_rd,
    output logic                    chr_we,
    output logic [7:0]              chr_wdata,
    input  logic [7:0]              chr_q,
    output logic [7:0]              rdata,
    output logic                    rvalid
);

    localparam int VRAM_AW    = (VRAM_KB == 4) ? 12 : 11;
    localparam int VRAM_DEPTH = 1 << VRAM_AW;

    target_e                 map_tgt;
    logic [CHR_BANK_W+11:0]  map_chr_addr;
    logic [VRAM_AW-1:0]      map_vram_addr;
    logic [4:0]              map_pal_idx;

    logic                    s1_vld_q;
    logic                    s1_we_q;
    target_e                 s1_tgt_q;
    logic [CHR_BANK_W+11:0]  s1_chr_addr_q;
    logic [VRAM_AW-1:0]      s1_vram_addr_q;
    logic [4:0]              s1_pal_idx_q;
    logic [7:0]              s1_wdata_q;

    logic                    s2_vld_q;
    logic                    s2_we_q;
    target_e                 s2_tgt_q;

    logic [7:0]              vram_mem [VRAM_DEPTH];
    logic [7:0]              vram_q;
    logic [5:0]              pal_q [32];
    logic [5:0]              pal_rd_q;

    logic [7:0]              rdata_d;
    logic [7:0]              rdata_hold_q;

    logic                    s1_is_nt;
    logic                    s1_is_pal;
    logic                    s1_is_chr;

    ppu_addr_map #(
        .VRAM_KB    (VRAM_KB),
        .CHR_BANK_W (CHR_BANK_W)
    ) u_addr_map (
        .addr        (addr),
        .mirror_mode (mirror_mode),
        .chr_bank0   (chr_bank0),
        .chr_bank1   (chr_bank1),
        .tgt         (map_tgt),
        .chr_addr    (map_chr_addr),
        .vram_addr   (map_vram_addr),
        .pal_idx     (map_pal_idx)
    );

    // S1: latch the translated request so later mode/bank changes cannot touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q       <= 1'b0;
            s1_we_q        <= 1'b0;
            s1_tgt_q       <= TGT_CHR;
            s1_chr_addr_q  <= '0;
            s1_vram_addr_q <= '0;
            s1_pal_idx_q   <= '0;
            s1_wdata_q     <= '0;
        end else begin
            s1_vld_q <= req;
            if (req) begin
                s1_we_q        <= we;
                s1_tgt_q       <= map_tgt;
                s1_chr_addr_q  <= map_chr_addr;
                s1_vram_addr_q <= map_vram_addr;
                s1_pal_idx_q   <= map_pal_idx;
                s1_wdata_q     <= wdata;
            end
        end
    end

    assign s1_is_nt  = s1_vld_q && (s1_tgt_q == TGT_NT);
    assign s1_is_pal = s1_vld_q && (s1_tgt_q == TGT_PAL);
    assign s1_is_chr = s1_vld_q && (s1_tgt_q == TGT_CHR);

    assign chr_addr  = s1_chr_addr_q;
    assign chr_wdata = s1_wdata_q;
    assign chr_rd    = s1_is_chr && !s1_we_q;
    assign chr_we    = (CHR_RAM != 0) && s1_is_chr && s1_we_q;

    // S2: nametable RAM access; no reset so it maps onto a block RAM.
    always_ff @(posedge clk) begin
        if (s1_is_nt) begin
            if (s1_we_q) begin
                vram_mem[s1_vram_addr_q] <= s1_wdata_q;
            end else begin
                vram_q <= vram_mem[s1_vram_addr_q];
            end
        end
    end

    // S2: palette flop array access, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                pal_q[i] <= '0;
            end
            pal_rd_q <= '0;
        end else if (s1_is_pal) begin
            if (s1_we_q) begin
                pal_q[s1_pal_idx_q] <= s1_wdata_q[5:0];
            end else begin
                pal_rd_q <= pal_q[s1_pal_idx_q];
            end
        end
    end

    // S2 -> S3: carry the target so the return mux follows the request, not the current input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            s2_we_q  <= 1'b0;
            s2_tgt_q <= TGT_CHR;
        end else begin
            s2_vld_q <= s1_vld_q;
            s2_we_q  <= s1_we_q;
            s2_tgt_q <= s1_tgt_q;
        end
    end

    // S3: select the returning data source.
    always_comb begin
        case (s2_tgt_q)
            TGT_CHR: rdata_d = chr_q;
            TGT_PAL: rdata_d = {2'b00, pal_rd_q};
            default: rdata_d = vram_q;
        endcase
    end

    assign rvalid = s2_vld_q && !s2_we_q;

    // Keep the last returned byte so rdata is stable between read pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_hold_q <= '0;
        end else if (rvalid) begin
            rdata_hold_q <= rdata_d;
        end
    end

    assign rdata = rvalid ? rdata_d : rdata_hold_q;

endmodule

// File: tb/tb_ppu_mem_ctrl.sv
// Randomised bench for ppu_mem_ctrl against a flat-memory reference model.
module tb_ppu_mem_ctrl;
    import ppu_mem_pkg::*;

    localparam int W = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [13:0]   addr;
    logic [7:0]    wdata;
    logic [2:0]    mirror_mode;
    logic [W-1:0]  chr_bank0;
    logic [W-1:0]  chr_bank1;
    logic [W+11:0] chr_addr;
    logic          chr_rd;
    logic          chr_we;
    logic [7:0]    chr_wdata;
    logic [7:0]    chr_q;
    logic [7:0]    rdata;
    logic          rvalid;

    ppu_mem_ctrl #(
        .VRAM_KB    (2),
        .CHR_BANK_W (W),
        .CHR_RAM    (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .mirror_mode (mirror_mode),
        .chr_bank0   (chr_bank0),
        .chr_bank1   (chr_bank1),
        .chr_addr    (chr_addr),
        .chr_rd      (chr_rd),
        .chr_we      (chr_we),
        .chr_wdata   (chr_wdata),
        .chr_q       (chr_q),
        .rdata       (rdata),
        .rvalid      (rvalid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] chr_pat(input logic [12:0] a);
        logic [7:0] h;
        h = 8'({3'b000, a[12:8]} * 8'd37);
        return a[7:0] ^ h;
    endfunction

    // External CHR ROM: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (chr_rd) chr_q <= chr_pat(chr_addr);
    end

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         known;
    } exp_t;

    logic [7:0]  m_vram [2048];
    bit          m_known [2048];
    logic [5:0]  m_pal [32];
    exp_t        expq[$];
    bit          pend_rd;
    logic [12:0] pend_addr;
    logic [7:0]  last_rdata;
    bit          last_known;
    int          cyc;
    int          n_chk;
    int          n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    function automatic int nt_phys(input logic [13:0] a, input logic [2:0] mm);
        int nt;
        int page;
        nt = int'(a[11:10]);
        case (mm)
            3'd1:    page = nt % 2;
            3'd2:    page = 0;
            3'd3:    page = 1;
            3'd4:    page = nt % 2;
            default: page = nt / 2;
        endcase
        return page * 1024 + int'(a[9:0]);
    endfunction

    // One clock cycle: apply a request, update the model, check outputs at negedge.
    task automatic step(input logic rq, input logic wr, input logic [13:0] a,
                        input logic [7:0] wd, input logic [2:0] mm,
                        input logic b0, input logic b1);
        logic        nx_rd;
        logic [12:0] nx_addr;
        logic [4:0]  idx;
        int          p;
        exp_t        e;
        nx_rd   = 1'b0;
        nx_addr = '0;
        req = rq; we = wr; addr = a; wdata = wd; mirror_mode = mm;
        chr_bank0 = b0; chr_bank1 = b1;
        e.due = cyc + 2;
        if (rq) begin
            if (a[13] == 1'b0) begin
                if (!wr) begin
                    nx_rd   = 1'b1;
                    nx_addr = {(a[12] ? b1 : b0), a[11:0]};
                    e.data  = chr_pat(nx_addr);
                    e.known = 1'b1;
                    expq.push_back(e);
                end
            end else if (a[13:8] == 6'h3F) begin
                idx = a[4:0];
                if (idx[1:0] == 2'b00) idx[4] = 1'b0;
                if (wr) m_pal[idx] = wd[5:0];
                else begin
                    e.data  = {2'b00, m_pal[idx]};
                    e.known = 1'b1;
                    expq.push_back(e);
                end
            end else begin
                p = nt_phys(a, mm);
                if (wr) begin
                    m_vram[p]  = wd;
                    m_known[p] = 1'b1;
                end else begin
                    e.data  = m_vram[p];
                    e.known = m_known[p];
                    expq.push_back(e);
                end
            end
        end
        @(negedge clk);
        chk("chr_rd", 32'(chr_rd), 32'(pend_rd));
        chk("chr_we", 32'(chr_we), 32'd0);
        if (pend_rd) chk("chr_addr", 32'(chr_addr), 32'(pend_addr));
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            chk("rvalid", 32'(rvalid), 32'd1);
            if (e.known) chk("rdata", 32'(rdata), 32'(e.data));
            last_rdata = e.data;
            last_known = e.known;
        end else begin
            chk("rvalid_idle", 32'(rvalid), 32'd0);
            if (last_known) chk("rdata_hold", 32'(rdata), 32'(last_rdata));
        end
        pend_rd   = nx_rd;
        pend_addr = nx_addr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 14'h0, 8'h0, 3'd0, 1'b0, 1'b0);
    endtask

    // Write is sampled, then reset lands before its access stage: nothing may commit.
    task automatic reset_mid();
        req = 1'b1; we = 1'b1; addr = 14'h2005; wdata = 8'h77; mirror_mode = 3'd0;
        chr_bank0 = 1'b0; chr_bank1 = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 1'b0; we = 1'b0;
        #2;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_chr_rd", 32'(chr_rd), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        pend_rd = 1'b0;
        for (int i = 0; i < 32; i++) m_pal[i] = '0;
        last_rdata = 8'h00;
        last_known = 1'b1;
        cyc += 2;
    endtask

    initial begin
        logic        r_rq, r_we, r_b0, r_b1;
        logic [13:0] r_a;
        logic [2:0]  r_mm;
        int          sel;
        n_chk = 0; n_pass = 0; cyc = 0;
        pend_rd = 1'b0; pend_addr = '0;
        last_rdata = 8'h00; last_known = 1'b1;
        for (int i = 0; i < 2048; i++) m_known[i] = 1'b0;
        for (int i = 0; i < 32; i++) m_pal[i] = '0;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        mirror_mode = '0; chr_bank0 = '0; chr_bank1 = '0;
        #12;
        chk("init_rvalid", 32'(rvalid), 32'd0);
        chk("init_rdata", 32'(rdata), 32'd0);
        chk("init_chr_rd", 32'(chr_rd), 32'd0);
        chk("init_chr_we", 32'(chr_we), 32'd0);
        chk("init_chr_addr", 32'(chr_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(2);

        // Horizontal mirroring
        step(1, 1, 14'h2805, 8'h11, 3'd0, 0, 0);
        step(1, 1, 14'h2005, 8'hA5, 3'd0, 0, 0);
        step(1, 0, 14'h2405, 8'h00, 3'd0, 0, 0);
        step(1, 0, 14'h2805, 8'h00, 3'd0, 0, 0);
        // Vertical mirroring and 0x3000 alias
        step(1, 1, 14'h2800, 8'h3C, 3'd1, 0, 0);
        step(1, 0, 14'h2000, 8'h00, 3'd1, 0, 0);
        step(1, 0, 14'h3000, 8'h00, 3'd1, 0, 0);
        // Palette aliasing and width
        step(1, 1, 14'h3F10, 8'hFF, 3'd0, 0, 0);
        step(1, 0, 14'h3F00, 8'h00, 3'd0, 0, 0);
        step(1, 1, 14'h3F01, 8'h12, 3'd0, 0, 0);
        step(1, 1, 14'h3F11, 8'h2A, 3'd0, 0, 0);
        step(1, 0, 14'h3F11, 8'h00, 3'd0, 0, 0);
        step(1, 0, 14'h3F01, 8'h00, 3'd0, 0, 0);
        // CHR banking, dropped CHR write
        step(1, 0, 14'h1234, 8'h00, 3'd0, 0, 1);
        step(1, 1, 14'h0100, 8'h5A, 3'd0, 0, 1);
        step(1, 0, 14'h0234, 8'h00, 3'd0, 1, 0);
        // Streaming across regions
        step(1, 0, 14'h0ABC, 8'h00, 3'd0, 0, 0);
        step(1, 0, 14'h2005, 8'h00, 3'd0, 0, 0);
        step(1, 0, 14'h3F00, 8'h00, 3'd0, 0, 0);
        step(1, 0, 14'h2405, 8'h00, 3'd0, 0, 0);
        // One-screen and four-screen (degraded) modes
        step(1, 1, 14'h2C07, 8'h61, 3'd3, 0, 0);
        step(1, 0, 14'h2007, 8'h00, 3'd3, 0, 0);
        step(1, 0, 14'h2C05, 8'h00, 3'd4, 0, 0);
        step(1, 0, 14'h2805, 8'h00, 3'd2, 0, 0);
        idle(3);

        reset_mid();
        idle(2);
        step(1, 0, 14'h2005, 8'h00, 3'd0, 0, 0);
        step(1, 0, 14'h3F00, 8'h00, 3'd0, 0, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            r_rq = ($urandom_range(0, 9) != 0);
            r_we = ($urandom_range(0, 2) == 0);
            sel  = int'($urandom_range(0, 9));
            r_a  = 14'($urandom);
            if (sel < 2) r_a[13] = 1'b0;
            else if (sel < 4) r_a[13:8] = 6'h3F;
            else r_a[13] = 1'b1;
            r_mm = 3'($urandom_range(0, 7));
            r_b0 = 1'($urandom);
            r_b1 = 1'($urandom);
            step(r_rq, r_we, r_a, 8'($urandom), r_mm, r_b0, r_b1);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ppu_mem_ctrl.md
# ppu_mem_ctrl

Parametrised PPU-side memory controller. It decodes the 14-bit PPU bus address into CHR (pattern), nametable VRAM and palette regions. It applies run-time-selectable nametable mirroring and CHR bank switching, and returns read data through a fixed-latency pipeline with a valid strobe. It sits between the PPU core and the per-game CHR storage, and replaces fixed per-game mirroring lists with a mode input driven by the cartridge/mapper logic.

## Interface
Parameters:
- `VRAM_KB`, default 2: internal nametable RAM size, 2 or 4 (4 enables true four-screen).
- `CHR_BANK_W`, default 1: width of each 4 KB CHR bank select; CHR address width is `CHR_BANK_W+12`.
- `CHR_RAM`, default 0: 1 means CHR is writable (CHR RAM); 0 means CHR writes are dropped.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: access request, one per cycle, always accepted.
- `we` in 1: 1 = write, 0 = read; sampled with `req`.
- `addr` in 14: PPU address.
- `wdata` in 8: write data.
- `mirror_mode` in 3: `mirror_e` value; sampled with `req`.
- `chr_bank0` in `CHR_BANK_W`: bank for `addr[12]`=0.
- `chr_bank1` in `CHR_BANK_W`: bank for `addr[12]`=1.
- `chr_addr` out `CHR_BANK_W+12`: CHR storage address.
- `chr_rd` out 1: CHR read strobe.
- `chr_we` out 1: CHR write strobe.
- `chr_wdata` out 8: CHR write data.
- `chr_q` in 8: CHR read data, one cycle after `chr_rd`.
- `rdata` out 8: read data.
- `rvalid` out 1: `rdata` valid, 1-cycle pulse per read.

## Operation
Address decode:
- `addr[13]`=0: CHR. `chr_addr = {bank, addr[11:0]}`, where `bank` is `chr_bank1` if `addr[12]`, else `chr_bank0`.
- `addr[13]`=1 and `addr[11:8]`≠4'hF, or `addr[12]`=0: nametable. 0x3000–0x3EFF aliases 0x2000–0x2EFF. `nt=addr[11:10]`, `off=addr[9:0]`.
- `addr[13:8]`=6'h3F: palette, index `addr[4:0]`. When `addr[1:0]`=0, bit 4 is cleared (0x3F10/14/18/1C alias 0x3F00/04/08/0C).

Mirroring (`mirror_e`), giving physical page p and VRAM address `{p, off}`:
- `MIR_HORZ`: p = `nt[1]`.
- `MIR_VERT`: p = `nt[0]`.
- `MIR_ONE_A`: p = 0.
- `MIR_ONE_B`: p = 1.
- `MIR_FOUR`: p = `nt` (2 bits). When `VRAM_KB`=2 it behaves as `MIR_VERT`.
- Reserved encodings behave as `MIR_HORZ`.

Storage:
- VRAM: internal single-port synchronous RAM, `VRAM_KB`×1024×8.
- Palette: 32×6 flop array. Reads return `{2'b00, pal}`. Writes store `wdata[5:0]`.
- CHR writes: with `CHR_RAM`=0, `chr_we` never asserts and the write is silently dropped.

Pipeline (request in cycle N):
- S1, cycle N: decode and translate, then register target, translated address, `we`, `wdata`.
- S2, cycle N+1: the memory op is issued. VRAM read/write, `chr_rd`/`chr_we` plus `chr_addr`, or palette read/write. Writes commit at the end of N+1.
- S3, cycle N+2: `rdata` is driven from the registered VRAM q, `chr_q`, or the registered palette read; `rvalid`=1 for reads only.

## Timing
- Read latency is exactly 2 cycles, `req` to `rvalid`. Throughput is 1 access per cycle. No backpressure.
- Write at N followed by a read of the same location at N+1 returns the new data (write commits before the read's S2).
- Back-to-back reads to different regions keep order and latency; the output mux is selected by the S3-registered target.
- `mirror_mode`/`chr_bank*` changes affect only requests sampled after the change; in-flight ops use their S1-latched translation.
- Reset values: `rvalid`=0, `rdata`=8'h00, `chr_rd`=0, `chr_we`=0, `chr_addr`=0, `chr_wdata`=0, pipeline valid bits 0, palette 0.
- Reset mid-operation drops in-flight ops: no `rvalid` and no write commit. VRAM contents are undefined after reset.
- `rdata` holds its last value while `rvalid`=0.

## Structure
- Package `ppu_mem_pkg`: `mirror_e` (`MIR_HORZ`=0, `MIR_VERT`=1, `MIR_ONE_A`=2, `MIR_ONE_B`=3, `MIR_FOUR`=4), `target_e` (`TGT_CHR`, `TGT_NT`, `TGT_PAL`), region base constants.
- Sub-module `ppu_addr_map`: purely combinational decode, mirroring and palette aliasing. Unit-testable on its own.
- The VRAM is an inferred RAM inside `ppu_mem_ctrl`.

## Test plan
- **Horizontal mirroring:** `MIR_HORZ`, write 8'hA5 @0x2005, read 0x2405 → `rdata`=8'hA5 at N+2. Read 0x2805 → not A5.
- **Vertical mirroring and alias range:** `MIR_VERT`, write 8'h3C @0x2800, read 0x2000 and 0x3000 → both 8'h3C.
- **Palette aliasing and width:** write 8'hFF @0x3F10, read 0x3F00 → 8'h3F. Read 0x3F11 → not aliased to 0x3F01.
- **CHR banking:** `chr_bank1`=1, read 0x1234 → `chr_addr`=0x1234 with bit 12 set per bank (`{1, 12'h234}`), `chr_rd` at N+1. `CHR_RAM`=0 write → `chr_we` stays 0.
- **Streaming and ordering:** reads to CHR, NT, PAL, NT on consecutive cycles → 4 `rvalid` pulses on N+2..N+5 with matching data.
- **Reset mid-stream:** assert `rst` between a write `req` and its S2 → no commit, `rvalid`=0, `rdata`=8'h00.
